// File: rtl/sound_arbiter.sv
// sound_arbiter: single owner of the piezo playSound bus.
// Alarm beats outrank lullaby beats; handovers pass through a timed silence gap.
module sound_arbiter #(
    parameter int BEAT_W          = 13,
    parameter int SILENCE         = 0,
    parameter int GAP_TICKS       = 20,
    parameter int ALARM_MAX_TICKS = 6000
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              tick,
    input  logic              lullaby_req,
    input  logic [BEAT_W-1:0] lullaby_beat,
    input  logic              alarm_req,
    input  logic [BEAT_W-1:0] alarm_beat,
    input  logic              cancel,
    input  logic              mute,
    output logic [BEAT_W-1:0] play_sound,
    output logic              grant_lullaby,
    output logic              grant_alarm,
    output logic              busy,
    output logic              alarm_timeout
);

    typedef enum logic [2:0] {
        IDLE,
        LULL,
        ALARM,
        GAP,
        TIMEOUT
    } state_t;

    localparam logic [BEAT_W-1:0] SIL        = BEAT_W'(SILENCE);
    localparam logic [7:0]        GAP_LAST   = 8'(GAP_TICKS - 1);
    localparam logic [15:0]       ALARM_LAST = 16'(ALARM_MAX_TICKS - 1);

    state_t      state;
    state_t      state_nxt;
    logic [7:0]  gap_cnt;
    logic [7:0]  gap_nxt;
    logic [15:0] alarm_cnt;
    logic [15:0] alarm_nxt;

    // Next state and counter values; cancel overrides everything.
    always_comb begin
        state_nxt = state;
        gap_nxt   = gap_cnt;
        alarm_nxt = alarm_cnt;
        if (cancel) begin
            state_nxt = IDLE;
            gap_nxt   = '0;
            alarm_nxt = '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (alarm_req) begin
                        state_nxt = ALARM;
                        alarm_nxt = '0;
                    end else if (lullaby_req) begin
                        state_nxt = LULL;
                    end
                end
                LULL: begin
                    if (alarm_req) begin
                        state_nxt = GAP;
                        gap_nxt   = '0;
                    end else if (!lullaby_req) begin
                        state_nxt = IDLE;
                    end
                end
                ALARM: begin
                    if (!alarm_req) begin
                        state_nxt = GAP;
                        gap_nxt   = '0;
                    end else if (tick) begin
                        alarm_nxt = alarm_cnt + 16'd1;
                        if (alarm_cnt == ALARM_LAST) begin
                            state_nxt = TIMEOUT;
                        end
                    end
                end
                GAP: begin
                    if (tick) begin
                        if (gap_cnt == GAP_LAST) begin
                            if (alarm_req) begin
                                state_nxt = ALARM;
                                alarm_nxt = '0;
                            end else if (lullaby_req) begin
                                state_nxt = LULL;
                            end else begin
                                state_nxt = IDLE;
                            end
                        end else begin
                            gap_nxt = gap_cnt + 8'd1;
                        end
                    end
                end
                TIMEOUT: begin
                    if (!alarm_req) begin
                        state_nxt = IDLE;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // State, counters and outputs registered from the next state.
    always_ff @(posedge clock) begin
        if (reset) begin
            state         <= IDLE;
            gap_cnt       <= '0;
            alarm_cnt     <= '0;
            play_sound    <= SIL;
            grant_lullaby <= 1'b0;
            grant_alarm   <= 1'b0;
            busy          <= 1'b0;
            alarm_timeout <= 1'b0;
        end else begin
            state         <= state_nxt;
            gap_cnt       <= gap_nxt;
            alarm_cnt     <= alarm_nxt;
            grant_lullaby <= (state_nxt == LULL);
            grant_alarm   <= (state_nxt == ALARM);
            busy          <= (state_nxt != IDLE);
            alarm_timeout <= (state_nxt == TIMEOUT);
            if (mute) begin
                play_sound <= SIL;
            end else if (state_nxt == LULL) begin
                play_sound <= lullaby_beat;
            end else if (state_nxt == ALARM) begin
                play_sound <= alarm_beat;
            end else begin
                play_sound <= SIL;
            end
        end
    end

endmodule

// File: tb/tb_sound_arbiter.sv
// tb_sound_arbiter: directed scenarios with literal expectations, then
// randomized traffic checked every cycle against an ownership model.
module tb_sound_arbiter;

    localparam int BW   = 13;
    localparam int GAP  = 2;
    localparam int AMAX = 5;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          tick = 1'b0;
    logic          lullaby_req = 1'b0;
    logic [BW-1:0] lullaby_beat = '0;
    logic          alarm_req = 1'b0;
    logic [BW-1:0] alarm_beat = '0;
    logic          cancel = 1'b0;
    logic          mute = 1'b0;
    logic [BW-1:0] play_sound;
    logic          grant_lullaby;
    logic          grant_alarm;
    logic          busy;
    logic          alarm_timeout;

    int tests = 0;
    int fails = 0;
    int ticks_seen = 0;
    int tcnt = 0;

    // Model: who owns the piezo, remaining gap ticks, alarm ticks played.
    int owner = 0;
    bit in_gap = 0;
    int gap_left = 0;
    int played = 0;
    bit tmo = 0;
    bit started = 0;
    logic [BW-1:0] exp_play;

    sound_arbiter #(
        .BEAT_W(BW),
        .SILENCE(0),
        .GAP_TICKS(GAP),
        .ALARM_MAX_TICKS(AMAX)
    ) dut (
        .clock(clock),
        .reset(reset),
        .tick(tick),
        .lullaby_req(lullaby_req),
        .lullaby_beat(lullaby_beat),
        .alarm_req(alarm_req),
        .alarm_beat(alarm_beat),
        .cancel(cancel),
        .mute(mute),
        .play_sound(play_sound),
        .grant_lullaby(grant_lullaby),
        .grant_alarm(grant_alarm),
        .busy(busy),
        .alarm_timeout(alarm_timeout)
    );

    always #5 clock = ~clock;

    // One tick pulse every 4 clocks, updated just after the edge.
    always @(posedge clock) begin
        #2;
        tcnt = (tcnt + 1) % 4;
        tick = (tcnt == 0);
    end

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clock);
    endtask

    task pick_owner(input bit a, input bit l);
        if (a) begin
            owner  = 2;
            played = 0;
        end else if (l) begin
            owner = 1;
        end else begin
            owner = 0;
        end
    endtask

    task start_gap();
        owner    = 0;
        in_gap   = 1;
        gap_left = GAP;
    endtask

    // Model update at each edge, compare shortly after.
    always @(posedge clock) begin : model
        bit a, l, tk, cn, mu, rs;
        logic [BW-1:0] lb, ab;
        a  = alarm_req;
        l  = lullaby_req;
        tk = tick;
        cn = cancel;
        mu = mute;
        rs = reset;
        lb = lullaby_beat;
        ab = alarm_beat;
        if (tk) ticks_seen++;
        if (rs || cn) begin
            owner    = 0;
            in_gap   = 0;
            gap_left = 0;
            played   = 0;
            tmo      = 0;
            if (rs) started = 1;
        end else if (tmo) begin
            if (!a) tmo = 0;
        end else if (in_gap) begin
            if (tk) begin
                gap_left--;
                if (gap_left == 0) begin
                    in_gap = 0;
                    pick_owner(a, l);
                end
            end
        end else if (owner == 0) begin
            pick_owner(a, l);
        end else if (owner == 1) begin
            if (a) start_gap();
            else if (!l) owner = 0;
        end else begin
            if (!a) begin
                start_gap();
            end else if (tk) begin
                played++;
                if (played == AMAX) begin
                    owner = 0;
                    tmo   = 1;
                end
            end
        end
        if (rs || mu) exp_play = '0;
        else if (owner == 1) exp_play = lb;
        else if (owner == 2) exp_play = ab;
        else exp_play = '0;
        #1;
        if (started) begin
            chk("m_play", int'(play_sound), int'(exp_play));
            chk("m_grant_l", int'(grant_lullaby), int'(owner == 1));
            chk("m_grant_a", int'(grant_alarm), int'(owner == 2));
            chk("m_busy", int'(busy), int'(owner != 0 || in_gap || tmo));
            chk("m_timeout", int'(alarm_timeout), int'(tmo));
        end
    end

    initial begin : stim
        int t0;
        bit found;
        bit silent;

        // Reset state
        cyc(2);
        reset = 1'b0;
        chk("rst_play", int'(play_sound), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_grants", int'({grant_lullaby, grant_alarm}), 0);
        chk("rst_tmo", int'(alarm_timeout), 0);

        // Basic lullaby
        lullaby_beat = 13'd101;
        lullaby_req  = 1'b1;
        cyc(1);
        chk("lull_play", int'(play_sound), 101);
        chk("lull_grant", int'(grant_lullaby), 1);
        chk("lull_busy", int'(busy), 1);
        lullaby_req = 1'b0;
        cyc(1);
        chk("lull_drop_play", int'(play_sound), 0);
        chk("lull_drop_busy", int'(busy), 0);

        // Preemption through a 2-tick gap
        lullaby_req = 1'b1;
        cyc(1);
        alarm_beat = 13'd7;
        alarm_req  = 1'b1;
        cyc(1);
        chk("gap_busy", int'(busy), 1);
        chk("gap_play", int'(play_sound), 0);
        t0 = ticks_seen;
        found = 0;
        silent = 1;
        for (int i = 0; i < 40 && !found; i++) begin
            cyc(1);
            if (grant_alarm) found = 1;
            else if (play_sound != 0) silent = 0;
        end
        chk("pre_reached", int'(found), 1);
        chk("pre_gap_ticks", ticks_seen - t0, 2);
        chk("pre_silent", int'(silent), 1);
        chk("pre_play", int'(play_sound), 7);
        chk("pre_grant_l", int'(grant_lullaby), 0);

        // Timeout after 5 ticks of alarm, lullaby held off
        t0 = ticks_seen;
        found = 0;
        for (int i = 0; i < 60 && !found; i++) begin
            cyc(1);
            if (alarm_timeout) found = 1;
        end
        chk("to_reached", int'(found), 1);
        chk("to_ticks", ticks_seen - t0, 5);
        chk("to_play", int'(play_sound), 0);
        chk("to_grant_a", int'(grant_alarm), 0);
        cyc(6);
        chk("to_hold_l", int'(grant_lullaby), 0);
        chk("to_hold_play", int'(play_sound), 0);
        chk("to_hold_flag", int'(alarm_timeout), 1);
        alarm_req = 1'b0;
        cyc(1);
        chk("to_idle_busy", int'(busy), 0);
        chk("to_idle_flag", int'(alarm_timeout), 0);
        cyc(1);
        chk("to_lull_grant", int'(grant_lullaby), 1);
        chk("to_lull_play", int'(play_sound), 101);

        // Simultaneous requests from IDLE: alarm, no gap
        lullaby_req = 1'b0;
        cyc(1);
        lullaby_req = 1'b1;
        alarm_req   = 1'b1;
        cyc(1);
        chk("sim_grant_a", int'(grant_alarm), 1);
        chk("sim_grant_l", int'(grant_lullaby), 0);
        chk("sim_play", int'(play_sound), 7);

        // Cancel together with a tick during GAP
        alarm_req   = 1'b0;
        lullaby_req = 1'b0;
        cyc(1);
        chk("cg_busy", int'(busy), 1);
        for (int i = 0; i < 4 && !tick; i++) cyc(1);
        chk("cg_tick", int'(tick), 1);
        cancel = 1'b1;
        cyc(1);
        cancel = 1'b0;
        chk("cg_busy0", int'(busy), 0);
        chk("cg_out0", int'({play_sound, grant_lullaby, grant_alarm, alarm_timeout}), 0);

        // Mute during alarm still times out
        alarm_req = 1'b1;
        mute      = 1'b1;
        cyc(1);
        chk("mute_play", int'(play_sound), 0);
        chk("mute_grant_a", int'(grant_alarm), 1);
        t0 = ticks_seen;
        found = 0;
        for (int i = 0; i < 60 && !found; i++) begin
            cyc(1);
            if (alarm_timeout) found = 1;
        end
        chk("mute_to", int'(found), 1);
        chk("mute_to_ticks", ticks_seen - t0, 5);
        mute      = 1'b0;
        alarm_req = 1'b0;
        cyc(1);

        // Reset mid-GAP
        lullaby_req = 1'b1;
        cyc(1);
        alarm_req = 1'b1;
        cyc(1);
        chk("rg_busy", int'(busy), 1);
        reset = 1'b1;
        cyc(1);
        chk("rg_busy0", int'(busy), 0);
        chk("rg_out0", int'({play_sound, grant_lullaby, grant_alarm, alarm_timeout}), 0);
        reset       = 1'b0;
        alarm_req   = 1'b0;
        lullaby_req = 1'b0;
        cyc(1);

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 29) == 0) alarm_req = ~alarm_req;
            if ($urandom_range(0, 14) == 0) lullaby_req = ~lullaby_req;
            lullaby_beat = 13'($urandom);
            alarm_beat   = 13'($urandom);
            cancel = ($urandom_range(0, 59) == 0);
            mute   = ($urandom_range(0, 9) == 0);
            reset  = ($urandom_range(0, 499) == 0);
            cyc(1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
